argmax_classifier: RTL and testbench
====================================

ARGMAX_CLASSIFIER -- requirements
Module: argmax_classifier

Interface
REQ-001 SHALL have parameter N_CLASSES, default 10, number of perceptron activations per frame (2..16).
REQ-002 SHALL have parameter DATA_W, default 32, activation width, two's-complement signed.
REQ-003 SHALL have port s_axi_aclk, input, 1, single clock; all logic rising-edge.
REQ-004 SHALL have port s_axi_aresetn, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port a_tdata, input, DATA_W, signed perceptron activation.
REQ-006 SHALL have port a_tvalid, input, 1, activation beat valid.
REQ-007 SHALL have port a_tlast, input, 1, marks final activation of a frame.
REQ-008 SHALL have port a_tready, output, 1, block accepts a beat.
REQ-009 SHALL have port class_tdata, output, 4, winning class index.
REQ-010 SHALL have port class_max, output, DATA_W, winning activation value.
REQ-011 SHALL have port class_err, output, 1, frame length error for this result.
REQ-012 SHALL have port class_tvalid, output, 1, result valid.
REQ-013 SHALL have port class_tready, input, 1, consumer accepts result.

Function
REQ-014 SHALL implement two states: ACCUM (a_tready=1, class_tvalid=0) and HOLD (a_tready=0, class_tvalid=1).
REQ-015 SHALL accept a beat only on a cycle with a_tvalid=1 and a_tready=1; beat index counter idx (4 bits) increments per accepted beat.
REQ-016 SHALL load best value and best index unconditionally on beat idx=0.
REQ-017 SHALL, for idx>0, replace best only when a_tdata is strictly greater (signed) than best; ties keep lowest index.
REQ-018 SHALL compare full DATA_W signed; -2^(DATA_W-1) is a valid value, no saturation.
REQ-019 SHALL close the frame on the accepted beat where a_tlast=1 or idx=N_CLASSES-1, whichever first.
REQ-020 SHALL set the result's err flag when the closing beat has a_tlast=1 with idx<N_CLASSES-1 (short frame) or a_tlast=0 with idx=N_CLASSES-1 (long frame).
REQ-021 SHALL, on a closing beat, include that beat in the comparison and enter HOLD next cycle with class_tdata/class_max/class_err registered (latency 1 cycle from closing beat to class_tvalid=1).
REQ-022 SHALL hold class_tdata, class_max, class_err stable while class_tvalid=1 and class_tready=0.
REQ-023 SHALL, in HOLD with class_tready=1, return to ACCUM next cycle with idx=0 and class_tvalid=0.
REQ-024 SHALL accept no input during HOLD; a_tvalid is ignored and upstream beats stall.
REQ-025 SHALL, on a long-frame error, treat the next accepted beat as idx=0 of a new frame (excess beats are not discarded).
REQ-026 SHALL sustain one frame per N_CLASSES+1 cycles when a_tvalid and class_tready are held high.

Reset
REQ-027 SHALL, while s_axi_aresetn=0, asynchronously force state=ACCUM, idx=0, best=0, class_tdata=0, class_max=0, class_err=0, class_tvalid=0.
REQ-028 SHALL drive a_tready=0 during reset and 1 from the first clock edge after deassertion.
REQ-029 SHALL discard any partial frame or held result on reset assertion mid-operation; no result emitted for it.

Verification
REQ-030 SHALL cover: 10 beats values 5,-3,7,7,0,1,2,3,4,6, tlast on beat 9, class_tready=1 -> class_tdata=2, class_max=7, class_err=0, class_tvalid one cycle after beat 9.
REQ-031 SHALL cover: all 10 beats = 32'h80000000 -> class_tdata=0, class_max=32'h80000000, class_err=0.
REQ-032 SHALL cover: 4 beats 1,9,2,3 with tlast on beat 3 -> class_tdata=1, class_max=9, class_err=1; next frame starts at idx 0.
REQ-033 SHALL cover: class_tready=0 for 20 cycles after result -> class_tvalid stays 1, outputs stable, a_tready=0; releases one cycle after class_tready=1.
REQ-034 SHALL cover: reset asserted after beat 5 of a frame -> all outputs 0 immediately; following full frame of values 0..9 -> class_tdata=9, class_max=9.
REQ-035 SHALL cover: back-to-back frames with a_tvalid, class_tready constant 1 -> one result every 11 cycles, each matching a reference argmax model.

Source files
------------

// File: rtl/argmax_classifier.sv
// Streaming argmax over a frame of signed perceptron activations.
// Accepts up to N_CLASSES beats per frame, then presents the winning class
// index, its activation and a frame-length error flag until consumed.
module argmax_classifier #(
  parameter int unsigned N_CLASSES = 10,
  parameter int unsigned DATA_W    = 32
) (
  input  logic              s_axi_aclk,
  input  logic              s_axi_aresetn,
  input  logic [DATA_W-1:0] a_tdata,
  input  logic              a_tvalid,
  input  logic              a_tlast,
  output logic              a_tready,
  output logic [3:0]        class_tdata,
  output logic [DATA_W-1:0] class_max,
  output logic              class_err,
  output logic              class_tvalid,
  input  logic              class_tready
);

  localparam int unsigned IDX_W = 4;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_CLASSES - 1);

  typedef enum logic {
    ST_ACCUM = 1'b0,
    ST_HOLD  = 1'b1
  } state_e;

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [DATA_W-1:0]  best_q, best_d;
  logic [IDX_W-1:0]   best_idx_q, best_idx_d;
  logic               a_tready_q, a_tready_d;
  logic [3:0]         class_tdata_q, class_tdata_d;
  logic [DATA_W-1:0]  class_max_q, class_max_d;
  logic               class_err_q, class_err_d;
  logic               class_tvalid_q, class_tvalid_d;

  logic               beat_ok;
  logic               take;
  logic               at_last_idx;
  logic               close;
  logic [DATA_W-1:0]  win_val;
  logic [IDX_W-1:0]   win_idx;

  // Beat qualification and running-max candidate selection.
  always_comb begin
    beat_ok     = a_tvalid && a_tready_q && (state_q == ST_ACCUM);
    // First beat always loads; later beats must be strictly greater so ties keep the lowest index.
    take        = (idx_q == '0) || ($signed(a_tdata) > $signed(best_q));
    at_last_idx = (idx_q == LAST_IDX);
    close       = a_tlast || at_last_idx;
    win_val     = take ? a_tdata : best_q;
    win_idx     = take ? idx_q : best_idx_q;
  end

  // Next-state and registered-output computation.
  always_comb begin
    state_d        = state_q;
    idx_d          = idx_q;
    best_d         = best_q;
    best_idx_d     = best_idx_q;
    class_tdata_d  = class_tdata_q;
    class_max_d    = class_max_q;
    class_err_d    = class_err_q;
    class_tvalid_d = class_tvalid_q;

    case (state_q)
      ST_ACCUM: begin
        if (beat_ok) begin
          best_d     = win_val;
          best_idx_d = win_idx;
          if (close) begin
            state_d        = ST_HOLD;
            idx_d          = '0;
            class_tdata_d  = 4'(win_idx);
            class_max_d    = win_val;
            // Short frame (early tlast) or long frame (missing tlast) both flag an error.
            class_err_d    = a_tlast ^ at_last_idx;
            class_tvalid_d = 1'b1;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      ST_HOLD: begin
        if (class_tready) begin
          state_d        = ST_ACCUM;
          class_tvalid_d = 1'b0;
        end
      end
      default: begin
        state_d        = ST_ACCUM;
        idx_d          = '0;
        class_tvalid_d = 1'b0;
      end
    endcase

    a_tready_d = (state_d == ST_ACCUM);
  end

  // State and output registers with asynchronous clear.
  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      state_q        <= ST_ACCUM;
      idx_q          <= '0;
      best_q         <= '0;
      best_idx_q     <= '0;
      a_tready_q     <= 1'b0;
      class_tdata_q  <= '0;
      class_max_q    <= '0;
      class_err_q    <= 1'b0;
      class_tvalid_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      idx_q          <= idx_d;
      best_q         <= best_d;
      best_idx_q     <= best_idx_d;
      a_tready_q     <= a_tready_d;
      class_tdata_q  <= class_tdata_d;
      class_max_q    <= class_max_d;
      class_err_q    <= class_err_d;
      class_tvalid_q <= class_tvalid_d;
    end
  end

  assign a_tready     = a_tready_q;
  assign class_tdata  = class_tdata_q;
  assign class_max    = class_max_q;
  assign class_err    = class_err_q;
  assign class_tvalid = class_tvalid_q;

endmodule

// File: tb/tb_argmax_classifier.sv
// Directed testbench for argmax_classifier (N_CLASSES=10, DATA_W=32).
module tb_argmax_classifier;

  logic        clk;
  logic        rst_n;
  logic [31:0] a_tdata;
  logic        a_tvalid;
  logic        a_tlast;
  logic        a_tready;
  logic [3:0]  class_tdata;
  logic [31:0] class_max;
  logic        class_err;
  logic        class_tvalid;
  logic        class_tready;

  int tests;
  int fails;
  int cyc;

  // Back-to-back frame vectors; expectations come from ref_idx below.
  int bv[30] = '{ 4, -2,  4,  1,  0, -7,  3,  2,  4,  1,
                 -5, -3, -9, -3, -1, -8, -1, -2, -6, -4,
                  0,  0,  0,  0,  0,  0,  0,  0,  0, 100};

  argmax_classifier #(.N_CLASSES(10), .DATA_W(32)) dut (
    .s_axi_aclk   (clk),
    .s_axi_aresetn(rst_n),
    .a_tdata      (a_tdata),
    .a_tvalid     (a_tvalid),
    .a_tlast      (a_tlast),
    .a_tready     (a_tready),
    .class_tdata  (class_tdata),
    .class_max    (class_max),
    .class_err    (class_err),
    .class_tvalid (class_tvalid),
    .class_tready (class_tready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic int ref_idx(input int base);
    int b = 0;
    for (int i = 1; i < 10; i++)
      if (bv[base + i] > bv[base + b]) b = i;
    return b;
  endfunction

  // Present one beat and return #1 after the edge on which it was accepted.
  task automatic send_beat(input logic [31:0] d, input logic last);
    int waits = 0;
    a_tdata  = d;
    a_tlast  = last;
    a_tvalid = 1'b1;
    while (a_tready !== 1'b1 && waits < 50) begin
      @(posedge clk); #1;
      waits++;
    end
    if (waits >= 50) begin
      tests++; fails++;
      $display("FAIL send_beat: a_tready stuck at %b, required 1", a_tready);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; a_tvalid = 1'b0; a_tlast = 1'b0; a_tdata = '0; class_tready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    tests++; if (a_tready !== 1'b0) begin fails++; $display("FAIL reset_a_tready: got %b required 0", a_tready); end
    tests++; if (class_tvalid !== 1'b0) begin fails++; $display("FAIL reset_tvalid: got %b required 0", class_tvalid); end
    tests++; if (class_tdata !== 4'd0) begin fails++; $display("FAIL reset_tdata: got %0d required 0", class_tdata); end
    tests++; if (class_max !== 32'd0) begin fails++; $display("FAIL reset_max: got %0h required 0", class_max); end
    tests++; if (class_err !== 1'b0) begin fails++; $display("FAIL reset_err: got %b required 0", class_err); end
    rst_n = 1'b1;
    #1;
    tests++; if (a_tready !== 1'b0) begin fails++; $display("FAIL deassert_a_tready_early: got %b required 0", a_tready); end
    @(posedge clk); #1;
    tests++; if (a_tready !== 1'b1) begin fails++; $display("FAIL deassert_a_tready: got %b required 1", a_tready); end
  endtask

  task automatic test_basic();
    int v[10] = '{5, -3, 7, 7, 0, 1, 2, 3, 4, 6};
    class_tready = 1'b1;
    for (int i = 0; i < 10; i++) send_beat(32'(v[i]), i == 9);
    a_tvalid = 1'b0;
    tests++; if (class_tvalid !== 1'b1) begin fails++; $display("FAIL basic_tvalid: got %b required 1", class_tvalid); end
    tests++; if (class_tdata !== 4'd2) begin fails++; $display("FAIL basic_tdata: got %0d required 2", class_tdata); end
    tests++; if (class_max !== 32'd7) begin fails++; $display("FAIL basic_max: got %0h required 7", class_max); end
    tests++; if (class_err !== 1'b0) begin fails++; $display("FAIL basic_err: got %b required 0", class_err); end
    tests++; if (a_tready !== 1'b0) begin fails++; $display("FAIL basic_hold_a_tready: got %b required 0", a_tready); end
    @(posedge clk); #1;
    tests++; if (class_tvalid !== 1'b0) begin fails++; $display("FAIL basic_release: got %b required 0", class_tvalid); end
    tests++; if (a_tready !== 1'b1) begin fails++; $display("FAIL basic_accum: got %b required 1", a_tready); end
  endtask

  task automatic test_min_value();
    for (int i = 0; i < 10; i++) send_beat(32'h8000_0000, i == 9);
    a_tvalid = 1'b0;
    tests++; if (class_tvalid !== 1'b1) begin fails++; $display("FAIL min_tvalid: got %b required 1", class_tvalid); end
    tests++; if (class_tdata !== 4'd0) begin fails++; $display("FAIL min_tdata: got %0d required 0", class_tdata); end
    tests++; if (class_max !== 32'h8000_0000) begin fails++; $display("FAIL min_max: got %0h required 80000000", class_max); end
    tests++; if (class_err !== 1'b0) begin fails++; $display("FAIL min_err: got %b required 0", class_err); end
    @(posedge clk); #1;
  endtask

  task automatic test_short_frame();
    int v[4]  = '{1, 9, 2, 3};
    int w[10] = '{3, 1, 4, 1, 5, 9, 2, 6, 5, 3};
    for (int i = 0; i < 4; i++) send_beat(32'(v[i]), i == 3);
    a_tvalid = 1'b0;
    tests++; if (class_tvalid !== 1'b1) begin fails++; $display("FAIL short_tvalid: got %b required 1", class_tvalid); end
    tests++; if (class_tdata !== 4'd1) begin fails++; $display("FAIL short_tdata: got %0d required 1", class_tdata); end
    tests++; if (class_max !== 32'd9) begin fails++; $display("FAIL short_max: got %0h required 9", class_max); end
    tests++; if (class_err !== 1'b1) begin fails++; $display("FAIL short_err: got %b required 1", class_err); end
    @(posedge clk); #1;
    for (int i = 0; i < 10; i++) send_beat(32'(w[i]), i == 9);
    a_tvalid = 1'b0;
    tests++; if (class_tvalid !== 1'b1) begin fails++; $display("FAIL short_next_tvalid: got %b required 1", class_tvalid); end
    tests++; if (class_tdata !== 4'd5) begin fails++; $display("FAIL short_next_tdata: got %0d required 5", class_tdata); end
    tests++; if (class_err !== 1'b0) begin fails++; $display("FAIL short_next_err: got %b required 0", class_err); end
    @(posedge clk); #1;
  endtask

  task automatic test_long_frame();
    for (int i = 0; i < 10; i++) send_beat(32'(i), 1'b0);
    tests++; if (class_tvalid !== 1'b1) begin fails++; $display("FAIL long_tvalid: got %b required 1", class_tvalid); end
    tests++; if (class_tdata !== 4'd9) begin fails++; $display("FAIL long_tdata: got %0d required 9", class_tdata); end
    tests++; if (class_max !== 32'd9) begin fails++; $display("FAIL long_max: got %0h required 9", class_max); end
    tests++; if (class_err !== 1'b1) begin fails++; $display("FAIL long_err: got %b required 1", class_err); end
    // The excess beat opens a new one-beat frame.
    send_beat(32'hFFFF_FFFB, 1'b1);
    a_tvalid = 1'b0;
    tests++; if (class_tvalid !== 1'b1) begin fails++; $display("FAIL excess_tvalid: got %b required 1", class_tvalid); end
    tests++; if (class_tdata !== 4'd0) begin fails++; $display("FAIL excess_tdata: got %0d required 0", class_tdata); end
    tests++; if (class_max !== 32'hFFFF_FFFB) begin fails++; $display("FAIL excess_max: got %0h required fffffffb", class_max); end
    tests++; if (class_err !== 1'b1) begin fails++; $display("FAIL excess_err: got %b required 1", class_err); end
    @(posedge clk); #1;
  endtask

  task automatic test_backpressure();
    class_tready = 1'b0;
    for (int i = 0; i < 10; i++) send_beat(32'(9 - i), i == 9);
    // Offer a beat that would win if it were wrongly accepted during hold.
    a_tvalid = 1'b1; a_tdata = 32'h7FFF_FFFF; a_tlast = 1'b1;
    for (int c = 0; c < 20; c++) begin
      tests++; if (class_tvalid !== 1'b1) begin fails++; $display("FAIL bp_tvalid c%0d: got %b required 1", c, class_tvalid); end
      tests++; if (class_tdata !== 4'd0) begin fails++; $display("FAIL bp_tdata c%0d: got %0d required 0", c, class_tdata); end
      tests++; if (class_max !== 32'd9) begin fails++; $display("FAIL bp_max c%0d: got %0h required 9", c, class_max); end
      tests++; if (class_err !== 1'b0) begin fails++; $display("FAIL bp_err c%0d: got %b required 0", c, class_err); end
      tests++; if (a_tready !== 1'b0) begin fails++; $display("FAIL bp_a_tready c%0d: got %b required 0", c, a_tready); end
      @(posedge clk); #1;
    end
    class_tready = 1'b1;
    @(posedge clk); #1;
    a_tvalid = 1'b0;
    tests++; if (class_tvalid !== 1'b0) begin fails++; $display("FAIL bp_release: got %b required 0", class_tvalid); end
    tests++; if (a_tready !== 1'b1) begin fails++; $display("FAIL bp_accum: got %b required 1", a_tready); end
  endtask

  task automatic test_reset_mid();
    class_tready = 1'b1;
    for (int i = 0; i < 6; i++) send_beat(32'(50 + i), 1'b0);
    #2 rst_n = 1'b0;
    #1;
    tests++; if (a_tready !== 1'b0) begin fails++; $display("FAIL midrst_a_tready: got %b required 0", a_tready); end
    tests++; if (class_tvalid !== 1'b0) begin fails++; $display("FAIL midrst_tvalid: got %b required 0", class_tvalid); end
    tests++; if (class_tdata !== 4'd0) begin fails++; $display("FAIL midrst_tdata: got %0d required 0", class_tdata); end
    tests++; if (class_max !== 32'd0) begin fails++; $display("FAIL midrst_max: got %0h required 0", class_max); end
    tests++; if (class_err !== 1'b0) begin fails++; $display("FAIL midrst_err: got %b required 0", class_err); end
    a_tvalid = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 10; i++) send_beat(32'(i), i == 9);
    a_tvalid = 1'b0;
    tests++; if (class_tdata !== 4'd9) begin fails++; $display("FAIL midrst_next_tdata: got %0d required 9", class_tdata); end
    tests++; if (class_max !== 32'd9) begin fails++; $display("FAIL midrst_next_max: got %0h required 9", class_max); end
    tests++; if (class_err !== 1'b0) begin fails++; $display("FAIL midrst_next_err: got %b required 0", class_err); end
    @(posedge clk); #1;
    // A held result is dropped by reset and never reappears.
    class_tready = 1'b0;
    send_beat(32'd77, 1'b1);
    a_tvalid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    tests++; if (class_tvalid !== 1'b0) begin fails++; $display("FAIL holdrst_tvalid: got %b required 0", class_tvalid); end
    @(posedge clk); #1 rst_n = 1'b1;
    class_tready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    tests++; if (class_tvalid !== 1'b0) begin fails++; $display("FAIL holdrst_after: got %b required 0", class_tvalid); end
    tests++; if (a_tready !== 1'b1) begin fails++; $display("FAIL holdrst_a_tready: got %b required 1", a_tready); end
  endtask

  task automatic test_back_to_back();
    int prev = 0;
    int exp_i;
    class_tready = 1'b1;
    for (int f = 0; f < 3; f++) begin
      for (int i = 0; i < 10; i++) send_beat(32'(bv[f*10 + i]), i == 9);
      exp_i = ref_idx(f*10);
      tests++; if (class_tvalid !== 1'b1) begin fails++; $display("FAIL b2b_tvalid f%0d: got %b required 1", f, class_tvalid); end
      tests++; if (class_tdata !== 4'(exp_i)) begin fails++; $display("FAIL b2b_tdata f%0d: got %0d required %0d", f, class_tdata, exp_i); end
      tests++; if (class_max !== 32'(bv[f*10 + exp_i])) begin fails++; $display("FAIL b2b_max f%0d: got %0h required %0h", f, class_max, 32'(bv[f*10 + exp_i])); end
      tests++; if (class_err !== 1'b0) begin fails++; $display("FAIL b2b_err f%0d: got %b required 0", f, class_err); end
      if (f > 0) begin
        tests++; if (cyc - prev != 11) begin fails++; $display("FAIL b2b_period f%0d: got %0d cycles required 11", f, cyc - prev); end
      end
      prev = cyc;
    end
    a_tvalid = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    tests = 0; fails = 0; cyc = 0;
    test_reset();
    test_basic();
    test_min_value();
    test_short_frame();
    test_long_frame();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
